mem_port_arbiter: RTL and testbench

//  Shares the single main-memory port between the icache controller (IC) and the LSQ.

---
 rtl/mem_port_arbiter_pkg.sv | 17 +
 rtl/mem_port_arbiter_if.sv | 46 ++++
 rtl/mem_port_arbiter_tag_table.sv | 60 ++++++
 rtl/mem_port_arbiter.sv | 100 ++++++++++
 tb/tb_mem_port_arbiter.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// Shared bus command encodings, owner ids and default sizes for the memory-port arbiter.
package mem_port_arbiter_pkg;
  localparam int NUM_MEM_TAG_BITS = 4;
  localparam int NUM_MEM_TAGS     = 15;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } bus_cmd_e;

  typedef enum logic {
    OWNER_IC  = 1'b0,
    OWNER_LSQ = 1'b1
  } owner_e;
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Request, memory and return-path signals around the memory-port arbiter.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int TAG_BITS = NUM_MEM_TAG_BITS
);
  bus_cmd_e              ic2arb_command;
  logic [63:0]           ic2arb_addr;
  bus_cmd_e              lsq2arb_command;
  logic [63:0]           lsq2arb_addr;
  logic [63:0]           lsq2arb_data;

  bus_cmd_e              arb2mem_command;
  logic [63:0]           arb2mem_addr;
  logic [63:0]           arb2mem_data;
  logic [TAG_BITS-1:0]   mem2arb_response;
  logic [TAG_BITS-1:0]   mem2arb_tag;
  logic [63:0]           mem2arb_data;

  logic [TAG_BITS-1:0]   arb2ic_response;
  logic [TAG_BITS-1:0]   arb2lsq_response;
  logic [TAG_BITS-1:0]   arb2ic_tag;
  logic [63:0]           arb2ic_data;
  logic [TAG_BITS-1:0]   arb2lsq_tag;
  logic [63:0]           arb2lsq_data;

  // Arbiter side.
  modport master (
    input  ic2arb_command, ic2arb_addr,
    input  lsq2arb_command, lsq2arb_addr, lsq2arb_data,
    input  mem2arb_response, mem2arb_tag, mem2arb_data,
    output arb2mem_command, arb2mem_addr, arb2mem_data,
    output arb2ic_response, arb2lsq_response,
    output arb2ic_tag, arb2ic_data, arb2lsq_tag, arb2lsq_data
  );

  // Requesters and memory side.
  modport slave (
    output ic2arb_command, ic2arb_addr,
    output lsq2arb_command, lsq2arb_addr, lsq2arb_data,
    output mem2arb_response, mem2arb_tag, mem2arb_data,
    input  arb2mem_command, arb2mem_addr, arb2mem_data,
    input  arb2ic_response, arb2lsq_response,
    input  arb2ic_tag, arb2ic_data, arb2lsq_tag, arb2lsq_data
  );
endinterface

// File: rtl/mem_port_arbiter_tag_table.sv
// Per-tag owner table for outstanding loads: record, clear, combinational lookup, live count.
module mem_tag_owner_table
  import mem_port_arbiter_pkg::*;
#(
  parameter int TAG_BITS = NUM_MEM_TAG_BITS,
  parameter int NUM_TAGS = NUM_MEM_TAGS
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                rec_en_i,
  input  logic [TAG_BITS-1:0] rec_tag_i,
  input  owner_e              rec_owner_i,
  input  logic                clr_en_i,
  input  logic [TAG_BITS-1:0] clr_tag_i,
  input  logic [TAG_BITS-1:0] lkp_tag_i,
  output logic                lkp_valid_o,
  output owner_e              lkp_owner_o,
  output logic                rec_collide_o,
  output logic [TAG_BITS-1:0] count_o
);
  localparam int DEPTH = NUM_TAGS + 1;

  logic [DEPTH-1:0] valid_q, valid_d;
  owner_e           owner_q [DEPTH];
  logic [TAG_BITS-1:0] count_q;

  function automatic logic [TAG_BITS-1:0] popcount(input logic [DEPTH-1:0] v);
    logic [TAG_BITS-1:0] c;
    c = '0;
    for (int i = 0; i < DEPTH; i++) c = c + {{(TAG_BITS-1){1'b0}}, v[i]};
    return c;
  endfunction

  assign lkp_valid_o = valid_q[lkp_tag_i];
  assign lkp_owner_o = owner_q[lkp_tag_i];
  // A same-cycle return of the tag being recorded is a legitimate reuse, not a collision.
  assign rec_collide_o = rec_en_i && valid_q[rec_tag_i] &&
                         !(clr_en_i && (clr_tag_i == rec_tag_i));
  assign count_o = count_q;

  always_comb begin
    valid_d = valid_q;
    if (clr_en_i) valid_d[clr_tag_i] = 1'b0;
    if (rec_en_i) valid_d[rec_tag_i] = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      valid_q <= '0;
      count_q <= '0;
    end else begin
      valid_q <= valid_d;
      count_q <= popcount(valid_d);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rec_en_i) owner_q[rec_tag_i] <= rec_owner_i;
  end
endmodule

// File: rtl/mem_port_arbiter.sv
// Grants the single memory port to IC or LSQ (LSQ-first with IC anti-starvation)
// and routes tagged load returns back to whichever requester issued them.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int TAG_BITS     = NUM_MEM_TAG_BITS,
  parameter int NUM_TAGS     = NUM_MEM_TAGS,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  mem_port_arbiter_if.master  bus_if,
  output logic [TAG_BITS-1:0] outstanding_o,
  output logic                err_unknown_tag_o
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q, starve_d;
  logic          err_q, err_d;
  logic          req_ic, req_lsq, grant_ic, grant_lsq, accepted;
  logic          rec_en, clr_en, lkp_valid, rec_collide, unknown_ret;
  owner_e        rec_owner, lkp_owner;
  bus_cmd_e      mem_cmd;

  always_comb begin
    req_ic    = (bus_if.ic2arb_command == BUS_LOAD);
    req_lsq   = (bus_if.lsq2arb_command != BUS_NONE);
    grant_ic  = req_ic && (!req_lsq || (starve_q == SW'(STARVE_LIMIT)));
    grant_lsq = req_lsq && !grant_ic;
    accepted  = (bus_if.mem2arb_response != '0);

    mem_cmd                 = BUS_NONE;
    bus_if.arb2mem_addr     = '0;
    bus_if.arb2mem_data     = '0;
    bus_if.arb2ic_response  = '0;
    bus_if.arb2lsq_response = '0;
    if (grant_ic) begin
      mem_cmd                = BUS_LOAD;
      bus_if.arb2mem_addr    = bus_if.ic2arb_addr;
      bus_if.arb2ic_response = bus_if.mem2arb_response;
    end else if (grant_lsq) begin
      mem_cmd                 = bus_if.lsq2arb_command;
      bus_if.arb2mem_addr     = bus_if.lsq2arb_addr;
      bus_if.arb2mem_data     = bus_if.lsq2arb_data;
      bus_if.arb2lsq_response = bus_if.mem2arb_response;
    end
    bus_if.arb2mem_command = mem_cmd;
  end

  assign rec_en    = accepted && (mem_cmd == BUS_LOAD);
  assign rec_owner = grant_lsq ? OWNER_LSQ : OWNER_IC;

  // Return path: data is broadcast, only the owner sees a non-zero tag.
  assign clr_en      = (bus_if.mem2arb_tag != '0) && lkp_valid;
  assign unknown_ret = (bus_if.mem2arb_tag != '0) && !lkp_valid;
  assign bus_if.arb2ic_tag   = (clr_en && lkp_owner == OWNER_IC)  ? bus_if.mem2arb_tag : '0;
  assign bus_if.arb2lsq_tag  = (clr_en && lkp_owner == OWNER_LSQ) ? bus_if.mem2arb_tag : '0;
  assign bus_if.arb2ic_data  = bus_if.mem2arb_data;
  assign bus_if.arb2lsq_data = bus_if.mem2arb_data;

  mem_tag_owner_table #(
    .TAG_BITS (TAG_BITS),
    .NUM_TAGS (NUM_TAGS)
  ) u_table (
    .clk_i         (clk_i),
    .rst_n_i       (rst_n_i),
    .rec_en_i      (rec_en),
    .rec_tag_i     (bus_if.mem2arb_response),
    .rec_owner_i   (rec_owner),
    .clr_en_i      (clr_en),
    .clr_tag_i     (bus_if.mem2arb_tag),
    .lkp_tag_i     (bus_if.mem2arb_tag),
    .lkp_valid_o   (lkp_valid),
    .lkp_owner_o   (lkp_owner),
    .rec_collide_o (rec_collide),
    .count_o       (outstanding_o)
  );

  // Any IC cycle without an accepted response, including a memory refusal, counts as denied.
  always_comb begin
    starve_d = starve_q;
    if (req_ic) begin
      if (grant_ic && accepted)             starve_d = '0;
      else if (starve_q != SW'(STARVE_LIMIT)) starve_d = starve_q + 1'b1;
    end
    err_d = err_q | unknown_ret | rec_collide;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      starve_q <= '0;
      err_q    <= 1'b0;
    end else begin
      starve_q <= starve_d;
      err_q    <= err_d;
    end
  end

  assign err_unknown_tag_o = err_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with hand-computed expectations.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [3:0] outstanding;
  logic       err_unknown_tag;
  int         total;
  int         bad;

  mem_port_arbiter_if bus ();

  mem_port_arbiter dut (
    .clk_i             (clk),
    .rst_n_i           (rst_n),
    .bus_if            (bus),
    .outstanding_o     (outstanding),
    .err_unknown_tag_o (err_unknown_tag)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.ic2arb_command   = BUS_NONE;
    bus.ic2arb_addr      = '0;
    bus.lsq2arb_command  = BUS_NONE;
    bus.lsq2arb_addr     = '0;
    bus.lsq2arb_data     = '0;
    bus.mem2arb_response = '0;
    bus.mem2arb_tag      = '0;
    bus.mem2arb_data     = '0;
  endtask

  logic [3:0] both_tags [4];
  logic [3:0] fill_tags [10];

  initial begin
    total = 0;
    bad   = 0;
    both_tags = '{4'd5, 4'd6, 4'd8, 4'd10};
    fill_tags = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd7, 4'd9, 4'd11, 4'd12, 4'd14, 4'd15};
    rst_n = 1'b0;
    idle();
    #2;
    chk("rst_outstanding", outstanding, 0);
    chk("rst_err", err_unknown_tag, 0);
    chk("rst_mem_cmd", bus.arb2mem_command, BUS_NONE);
    step();
    rst_n = 1'b1;
    step();

    // IC load alone, accepted on tag 3.
    bus.ic2arb_command = BUS_LOAD;
    bus.ic2arb_addr = 64'h100;
    bus.mem2arb_response = 4'd3;
    #1;
    chk("ic_mem_cmd", bus.arb2mem_command, BUS_LOAD);
    chk("ic_mem_addr", bus.arb2mem_addr, 64'h100);
    chk("ic_mem_data", bus.arb2mem_data, 0);
    chk("ic_resp", bus.arb2ic_response, 3);
    chk("ic_lsq_resp", bus.arb2lsq_response, 0);
    step();
    chk("ic_outstanding", outstanding, 1);

    // Tag 3 returns to IC.
    idle();
    bus.mem2arb_tag = 4'd3;
    bus.mem2arb_data = 64'hAA;
    #1;
    chk("ret3_ic_tag", bus.arb2ic_tag, 3);
    chk("ret3_ic_data", bus.arb2ic_data, 64'hAA);
    chk("ret3_lsq_tag", bus.arb2lsq_tag, 0);
    step();
    chk("ret3_outstanding", outstanding, 0);
    chk("ret3_err", err_unknown_tag, 0);

    // Both request: LSQ wins four times, then IC on the fifth.
    idle();
    bus.ic2arb_command = BUS_LOAD;
    bus.ic2arb_addr = 64'h300;
    bus.lsq2arb_command = BUS_LOAD;
    bus.lsq2arb_addr = 64'h400;
    for (int i = 0; i < 4; i++) begin
      bus.mem2arb_response = both_tags[i];
      #1;
      chk("both_lsq_resp", bus.arb2lsq_response, both_tags[i]);
      chk("both_ic_resp", bus.arb2ic_response, 0);
      chk("both_mem_addr", bus.arb2mem_addr, 64'h400);
      step();
      chk("both_outstanding", outstanding, 4'(i + 1));
    end
    bus.mem2arb_response = 4'd11;
    #1;
    chk("starve_ic_resp", bus.arb2ic_response, 11);
    chk("starve_lsq_resp", bus.arb2lsq_response, 0);
    chk("starve_mem_addr", bus.arb2mem_addr, 64'h300);
    step();
    chk("starve_outstanding", outstanding, 5);
    bus.mem2arb_response = 4'd13;
    #1;
    chk("starve_clr_lsq_resp", bus.arb2lsq_response, 13);
    chk("starve_clr_ic_resp", bus.arb2ic_response, 0);
    step();
    chk("starve_clr_outstanding", outstanding, 6);

    // LSQ store: forwarded, never recorded.
    idle();
    bus.lsq2arb_command = BUS_STORE;
    bus.lsq2arb_addr = 64'h200;
    bus.lsq2arb_data = 64'h55;
    bus.mem2arb_response = 4'd7;
    #1;
    chk("st_mem_cmd", bus.arb2mem_command, BUS_STORE);
    chk("st_mem_addr", bus.arb2mem_addr, 64'h200);
    chk("st_mem_data", bus.arb2mem_data, 64'h55);
    chk("st_lsq_resp", bus.arb2lsq_response, 7);
    step();
    chk("st_outstanding", outstanding, 6);

    // Tag 9 owned by IC, then returned and re-accepted for LSQ in one cycle.
    idle();
    bus.ic2arb_command = BUS_LOAD;
    bus.ic2arb_addr = 64'h800;
    bus.mem2arb_response = 4'd9;
    step();
    chk("t9_outstanding", outstanding, 7);
    idle();
    bus.lsq2arb_command = BUS_LOAD;
    bus.lsq2arb_addr = 64'h900;
    bus.mem2arb_response = 4'd9;
    bus.mem2arb_tag = 4'd9;
    bus.mem2arb_data = 64'h99;
    #1;
    chk("t9_old_ic_tag", bus.arb2ic_tag, 9);
    chk("t9_old_lsq_tag", bus.arb2lsq_tag, 0);
    chk("t9_new_lsq_resp", bus.arb2lsq_response, 9);
    step();
    chk("t9_reuse_outstanding", outstanding, 7);
    chk("t9_reuse_err", err_unknown_tag, 0);
    idle();
    bus.mem2arb_tag = 4'd9;
    bus.mem2arb_data = 64'h77;
    #1;
    chk("t9_new_lsq_tag", bus.arb2lsq_tag, 9);
    chk("t9_new_ic_tag", bus.arb2ic_tag, 0);
    chk("t9_new_lsq_data", bus.arb2lsq_data, 64'h77);
    step();
    chk("t9_ret_outstanding", outstanding, 6);

    // Tag 11 was the starvation grant, so it belongs to IC.
    bus.mem2arb_tag = 4'd11;
    #1;
    chk("t11_ic_tag", bus.arb2ic_tag, 11);
    chk("t11_lsq_tag", bus.arb2lsq_tag, 0);
    step();
    chk("t11_outstanding", outstanding, 5);

    // Unknown tag 12: dropped, sticky error.
    bus.mem2arb_tag = 4'd12;
    #1;
    chk("t12_ic_tag", bus.arb2ic_tag, 0);
    chk("t12_lsq_tag", bus.arb2lsq_tag, 0);
    step();
    chk("t12_err", err_unknown_tag, 1);
    chk("t12_outstanding", outstanding, 5);
    idle();
    step();
    chk("t12_err_sticky", err_unknown_tag, 1);

    // Fill remaining tags, then reset mid-run.
    for (int i = 0; i < 10; i++) begin
      bus.ic2arb_command = BUS_LOAD;
      bus.ic2arb_addr = 64'h1000 + 64'(i);
      bus.mem2arb_response = fill_tags[i];
      step();
    end
    chk("fill_outstanding", outstanding, 15);
    idle();
    rst_n = 1'b0;
    #1;
    chk("midrst_outstanding", outstanding, 0);
    chk("midrst_err", err_unknown_tag, 0);
    chk("midrst_mem_cmd", bus.arb2mem_command, BUS_NONE);
    #2;
    rst_n = 1'b1;
    step();
    bus.mem2arb_tag = 4'd4;
    bus.mem2arb_data = 64'h44;
    #1;
    chk("stale_ic_tag", bus.arb2ic_tag, 0);
    chk("stale_lsq_tag", bus.arb2lsq_tag, 0);
    step();
    chk("stale_err", err_unknown_tag, 1);
    chk("stale_outstanding", outstanding, 0);
    idle();
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
